serial_alu_seq: RTL

Bit-serial word ALU sequencer: the initiator side of the 1-bit ALU slice interface (A, B, CIN, F1, F0 → RES, COUT). It accepts one WIDTH-bit operation through a valid/ready handshake and drives the slice one bit per cycle, LSB first, chaining COUT back to CIN. It assembles RES into a result word and returns it through a second valid/ready handshake. It sits between a word-level requester and a single shared 1-bit ALU slice, giving word arithmetic at one slice's area.

---
 rtl/serial_alu_pkg.sv | 15 +
 rtl/serial_alu_slice.sv | 33 +++
 rtl/serial_alu_seq.sv | 100 ++++++++++
 3 files changed

// File: rtl/serial_alu_pkg.sv
// rtl/serial_alu_pkg.sv - shared op codes and sequencer state type for the serial ALU
package serial_alu_pkg;

  localparam logic [1:0] OP_AND = 2'b00;
  localparam logic [1:0] OP_OR  = 2'b01;
  localparam logic [1:0] OP_XOR = 2'b10;
  localparam logic [1:0] OP_ADD = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/serial_alu_slice.sv
// rtl/serial_alu_slice.sv - combinational 1-bit ALU slice (and/or/xor/add)
module serial_alu_slice
  import serial_alu_pkg::*;
(
  input  logic a,
  input  logic b,
  input  logic cin,
  input  logic f1,
  input  logic f0,
  output logic res,
  output logic cout
);

  // Select the bit function; carry only propagates for ADD
  always_comb begin
    res  = 1'b0;
    cout = 1'b0;
    case ({f1, f0})
      OP_AND: res = a & b;
      OP_OR:  res = a | b;
      OP_XOR: res = a ^ b;
      OP_ADD: begin
        res  = a ^ b ^ cin;
        cout = (a & b) | (a & cin) | (b & cin);
      end
      default: begin
        res  = 1'b0;
        cout = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/serial_alu_seq.sv
// rtl/serial_alu_seq.sv - word-level sequencer driving one shared 1-bit ALU slice LSB first
module serial_alu_seq
  import serial_alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin_init,
  output logic             done_valid,
  input  logic             done_ready,
  output logic [WIDTH-1:0] result,
  output logic             cout
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  state_t           state;
  logic [1:0]       op_q;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] res_sh;
  logic [WIDTH-1:0] res_sh_nxt;
  logic             carry;
  logic [CW-1:0]    cnt;
  logic             s_res;
  logic             s_cout;
  logic             accept;
  logic             last_bit;

  serial_alu_slice u_slice (
    .a    (a_sh[0]),
    .b    (b_sh[0]),
    .cin  (carry),
    .f1   (op_q[1]),
    .f0   (op_q[0]),
    .res  (s_res),
    .cout (s_cout)
  );

  // A finishing result can be consumed and a new op accepted on the same edge
  assign start_ready = (state == IDLE) | ((state == DONE) & done_ready);
  assign accept      = start_valid & start_ready;
  assign last_bit    = (cnt == CW'(WIDTH - 1));

  // Next result shift value: slice output enters at the MSB, LSB-first bits settle into place
  always_comb begin
    res_sh_nxt            = res_sh >> 1;
    res_sh_nxt[WIDTH-1]   = s_res;
  end

  // Sequencer FSM with shift registers, bit counter and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      op_q       <= 2'b00;
      a_sh       <= '0;
      b_sh       <= '0;
      res_sh     <= '0;
      carry      <= 1'b0;
      cnt        <= '0;
      done_valid <= 1'b0;
      result     <= '0;
      cout       <= 1'b0;
    end else if (accept) begin
      state      <= RUN;
      op_q       <= op;
      a_sh       <= a;
      b_sh       <= b;
      carry      <= (op == OP_ADD) & cin_init;
      cnt        <= '0;
      done_valid <= 1'b0;
    end else if (state == RUN) begin
      a_sh   <= a_sh >> 1;
      b_sh   <= b_sh >> 1;
      res_sh <= res_sh_nxt;
      carry  <= s_cout;
      if (last_bit) begin
        cnt        <= '0;
        result     <= res_sh_nxt;
        cout       <= s_cout;
        done_valid <= 1'b1;
        state      <= DONE;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end else if ((state == DONE) && done_ready) begin
      done_valid <= 1'b0;
      state      <= IDLE;
    end else if ((state != IDLE) && (state != DONE)) begin
      state <= IDLE;
    end
  end

endmodule
